// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM state encoding,
// default sizing and the round-robin pointer advance helper.
package uart_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // Next requester index after id, wrapping from n-1 back to 0.
    function automatic int rr_next(input int id, input int n);
        int nxt;
        if (id >= n - 1) begin
            nxt = 0;
        end else begin
            nxt = id + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first valid requester at or
// after i_rr_ptr, wrapping past the highest index back to 0.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PICK_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [PICK_W-1:0]  i_rr_ptr,
    output logic [PICK_W-1:0]  o_winner,
    output logic               o_any_valid
);

    logic              w_found;
    logic [PICK_W-1:0] w_idx;
    int                w_sum;

    // Scan requesters starting at the pointer; the first valid one wins.
    always_comb begin
        o_winner    = {PICK_W{1'b0}};
        w_found     = 1'b0;
        w_idx       = {PICK_W{1'b0}};
        w_sum       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = (int'(i_rr_ptr) + k) % NUM_REQ;
            w_idx = PICK_W'(w_sum);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                o_winner = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
        o_any_valid = |i_req_valid;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte sources.
// Define UART_ARB_LOCK_EN to keep the grant on one requester until req_last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        tx_busy,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        grant_vld
);

    localparam int GID_W = $clog2(NUM_REQ);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic               w_accept;
    logic               w_done;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_elig;
    logic [GID_W-1:0]   w_winner;
    logic               w_any;
    logic [GID_W-1:0]   w_ptr_nxt;

    logic [GID_W-1:0]   r_rr_ptr;
    logic [GID_W-1:0]   r_grant_id;
    logic               r_grant_vld;
    logic               r_tx_start;
    logic [DATA_W-1:0]  r_tx_data;

`ifdef UART_ARB_LOCK_EN
    logic               r_lock;
    logic [NUM_REQ-1:0] w_lock_mask;

    // While a packet is open only its owner is eligible.
    assign w_lock_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
    assign w_elig      = r_lock ? (req_valid & w_lock_mask) : req_valid;
    assign w_ptr_nxt   = r_lock ? r_grant_id : GID_W'(rr_next(int'(r_grant_id), NUM_REQ));

    // Packet lock follows req_last of each accepted byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (w_accept) begin
            r_lock <= ~req_last[w_winner];
        end else begin
            r_lock <= r_lock;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_elig        = req_valid;
    assign w_ptr_nxt     = GID_W'(rr_next(int'(r_grant_id), NUM_REQ));
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PICK_W  (GID_W)
    ) u_rr_pick (
        .i_req_valid (w_elig),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; acceptance and req_ready only ever happen in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ready     = {NUM_REQ{1'b0}};
        case (r_state)
            IDLE: begin
                if (w_any && !tx_busy) begin
                    w_accept          = 1'b1;
                    w_ready[w_winner] = 1'b1;
                    w_state_nxt       = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else begin
                    w_state_nxt = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_done = (r_state == WAIT_DONE) && !tx_busy;

    // Grant bookkeeping, byte capture and the one-cycle start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_start  <= 1'b0;
            r_tx_data   <= {DATA_W{1'b0}};
            r_grant_id  <= {GID_W{1'b0}};
            r_grant_vld <= 1'b0;
            r_rr_ptr    <= {GID_W{1'b0}};
        end else begin
            r_tx_start <= w_accept;
            if (w_accept) begin
                r_tx_data   <= req_data[w_winner*DATA_W +: DATA_W];
                r_grant_id  <= w_winner;
                r_grant_vld <= 1'b1;
            end else if (w_done) begin
                r_grant_vld <= 1'b0;
                r_rr_ptr    <= w_ptr_nxt;
            end else begin
                r_grant_vld <= r_grant_vld;
            end
        end
    end

    assign req_ready = w_ready;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant_id;
    assign grant_vld = r_grant_vld;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural TX core and a
// transaction-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_last = '1;
    logic [NR-1:0]     req_ready;
    logic              tx_busy = 1'b0;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic [1:0]        grant_id;
    logic              grant_vld;

    int errors = 0;
    int checks = 0;

    int busy_cnt = 0;
    bit start_seen = 1'b0;
    bit force_busy = 1'b0;
    bit rand_frames = 1'b0;
    int frame_len = 10;

    logic [7:0] qd[NR][16];
    bit         ql[NR][16];
    int         qh[NR];
    int         qn[NR];
    bit         pop_pend[NR];

    logic [NR-1:0] rec_ready[$];
    logic [7:0]    rec_data[$];
    logic [1:0]    rec_gid[$];
    bit            rec_start_ok[$];
    bit            rec_vld_low[$];
    int            spurious;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    always #5 clk = ~clk;

    // UART TX core: busy rises the cycle after tx_start and lasts a frame.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy_cnt   = 0;
                start_seen = 1'b0;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (start_seen) busy_cnt = rand_frames ? int'($urandom_range(1, 12)) : frame_len;
                start_seen = tx_start;
            end
            tx_busy = force_busy || (busy_cnt > 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NR; i++) begin
            qh[i] = 0;
            qn[i] = 0;
            pop_pend[i] = 1'b0;
        end
        rec_ready.delete();
        rec_data.delete();
        rec_gid.delete();
        rec_start_ok.delete();
        rec_vld_low.delete();
        spurious = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_last = '1;
        force_busy = 1'b0;
        rand_frames = 1'b0;
        clear_queues();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drive_queues();
        for (int i = 0; i < NR; i++) begin
            if (pop_pend[i]) begin
                qh[i]++;
                pop_pend[i] = 1'b0;
            end
            if (qh[i] < qn[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DW +: DW] = qd[i][qh[i]];
                req_last[i] = ql[i][qh[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i] = 1'b1;
            end
        end
    endtask

    // Runs requesters from their queues and records each accept/start pair.
    task automatic collect(input int n, input int budget);
        bit pend = 1'b0;
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            step();
            drive_queues();
            @(negedge clk);
            if (pend) begin
                rec_start_ok.push_back(tx_start);
                rec_data.push_back(tx_data);
                rec_gid.push_back(grant_id);
                pend = 1'b0;
                got++;
            end else if (tx_start) begin
                spurious++;
            end
            if (req_ready != '0) begin
                rec_ready.push_back(req_ready);
                rec_vld_low.push_back(!grant_vld && !tx_busy);
                for (int i = 0; i < NR; i++) if (req_ready[i]) pop_pend[i] = 1'b1;
                pend = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        int t;
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        checks++; if (grant_vld !== 1'b0) begin errors++; $display("FAIL reset_grant_vld got=%b exp=0", grant_vld); end
        step();
        rst = 1'b0;
        step();
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'h66;
        t = 0;
        @(negedge clk);
        while (req_ready == '0 && t < 10) begin step(); @(negedge clk); t++; end
        step();
        req_valid = '0;
        t = 0;
        @(negedge clk);
        while (!tx_busy && t < 10) begin step(); @(negedge clk); t++; end
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_data !== 8'h00 || grant_vld !== 1'b0 || grant_id !== 2'd0 || tx_start !== 1'b0)
            begin errors++; $display("FAIL reset_mid_frame got data=%h vld=%b id=%0d start=%b exp all 0", tx_data, grant_vld, grant_id, tx_start); end
        step();
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr_restart got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
    endtask

    task automatic test_single();
        int t = 0;
        do_reset();
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'h55;
        @(negedge clk);
        while (req_ready == '0 && t < 10) begin step(); @(negedge clk); t++; end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_early got=%b exp=0", tx_start); end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", tx_start); end
        checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL single_data got=%h exp=55", tx_data); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid got=%0d exp=2", grant_id); end
        checks++; if (grant_vld !== 1'b1) begin errors++; $display("FAIL single_gvld got=%b exp=1", grant_vld); end
        step();
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse got=%b exp=0", tx_start); end
        t = 0;
        while (grant_vld && t < 40) begin step(); @(negedge clk); t++; end
        checks++; if (grant_vld !== 1'b0) begin errors++; $display("FAIL single_done got=%b exp=0", grant_vld); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NR; i++) begin
            qn[i] = 8;
            for (int j = 0; j < 8; j++) begin qd[i][j] = 8'(8'h10 + i); ql[i][j] = 1'b1; end
        end
        collect(5, 200);
        checks++; if (rec_start_ok.size() != 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", rec_start_ok.size()); end
        for (int k = 0; k < 5 && k < rec_start_ok.size(); k++) begin
            checks++; if (rec_gid[k] !== 2'(k % NR) || rec_data[k] !== 8'(8'h10 + k % NR) || rec_ready[k] !== (4'b0001 << (k % NR)) || !rec_start_ok[k])
                begin errors++; $display("FAIL rr_order[%0d] got id=%0d data=%h ready=%b start=%b exp id=%0d", k, rec_gid[k], rec_data[k], rec_ready[k], rec_start_ok[k], k % NR); end
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rr_spurious got=%0d exp=0", spurious); end
    endtask

    task automatic test_busy_holdoff();
        int bad = 0;
        int t = 0;
        do_reset();
        force_busy = 1'b1;
        step();
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 8'h77;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL holdoff_ready got=%0d cycles exp=0", bad); end
        force_busy = 1'b0;
        bad = 0;
        @(negedge clk);
        while (req_ready == '0 && t < 6) begin
            step();
            @(negedge clk);
            t++;
        end
        if (tx_busy && req_ready != '0) bad++;
        checks++; if (req_ready !== 4'b0010 || bad != 0) begin errors++; $display("FAIL holdoff_release got=%b busy=%b exp=0010", req_ready, tx_busy); end
        step();
        req_valid = '0;
    endtask

    task automatic test_lock();
        logic [7:0] exp_d[3];
        do_reset();
        qn[0] = 2; qd[0][0] = 8'h30; ql[0][0] = 1'b1; qd[0][1] = 8'hB0; ql[0][1] = 1'b1;
        collect(1, 40);
        qn[1] = 2; qd[1][0] = 8'hA1; ql[1][0] = 1'b0; qd[1][1] = 8'hA2; ql[1][1] = 1'b1;
        collect(3, 200);
        if (LOCK) begin exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hB0; end
        else begin exp_d[0] = 8'hA1; exp_d[1] = 8'hB0; exp_d[2] = 8'hA2; end
        checks++; if (rec_data.size() != 4) begin errors++; $display("FAIL lock_count got=%0d exp=4", rec_data.size()); end
        for (int k = 0; k < 3 && k + 1 < rec_data.size(); k++) begin
            checks++; if (rec_data[k+1] !== exp_d[k]) begin errors++; $display("FAIL lock_order[%0d] got=%h exp=%h", k, rec_data[k+1], exp_d[k]); end
        end
    endtask

    task automatic test_withdraw();
        int t = 0;
        int rdy = 0;
        int st = 0;
        do_reset();
        req_valid = 4'b0001;
        req_data[0 +: DW] = 8'h42;
        @(negedge clk);
        while (req_ready == '0 && t < 10) begin step(); @(negedge clk); t++; end
        step();
        req_valid = '0;
        t = 0;
        @(negedge clk);
        while (!tx_busy && t < 10) begin step(); @(negedge clk); t++; end
        step();
        step();
        req_valid = 4'b1000;
        req_data[3*DW +: DW] = 8'h99;
        @(negedge clk);
        if (req_ready != '0) rdy++;
        if (tx_start) st++;
        step();
        req_valid = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_ready != '0) rdy++;
            if (tx_start) st++;
            step();
        end
        checks++; if (rdy != 0) begin errors++; $display("FAIL withdraw_ready got=%0d exp=0", rdy); end
        checks++; if (st != 0) begin errors++; $display("FAIL withdraw_start got=%0d exp=0", st); end
        checks++; if (grant_vld !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL withdraw_grant got vld=%b id=%0d exp 0/0", grant_vld, grant_id); end
    endtask

    // Random queues checked against the transaction-level arbitration model.
    task automatic test_random(input int iter);
        int total;
        int ptr;
        int locked;
        int w;
        int h[NR];
        int exp_id[$];
        logic [7:0] exp_d[$];
        do_reset();
        rand_frames = 1'b1;
        total = 0;
        for (int i = 0; i < NR; i++) begin
            qn[i] = $urandom_range(0, 5);
            total += qn[i];
            for (int j = 0; j < qn[i]; j++) begin
                qd[i][j] = 8'($urandom);
                ql[i][j] = (j == qn[i] - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            h[i] = 0;
        end
        ptr = 0;
        locked = -1;
        for (int n = 0; n < total; n++) begin
            w = -1;
            if (locked >= 0) w = locked;
            else for (int k = 0; k < NR; k++) if (w < 0 && h[(ptr + k) % NR] < qn[(ptr + k) % NR]) w = (ptr + k) % NR;
            exp_id.push_back(w);
            exp_d.push_back(qd[w][h[w]]);
            if (LOCK && !ql[w][h[w]]) begin locked = w; ptr = w; end
            else begin locked = -1; ptr = (w + 1) % NR; end
            h[w]++;
        end
        collect(total, total * 30 + 40);
        checks++; if (rec_data.size() != total) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", iter, rec_data.size(), total); end
        for (int k = 0; k < total && k < rec_data.size(); k++) begin
            checks++; if (rec_gid[k] !== 2'(exp_id[k]) || rec_data[k] !== exp_d[k] || !rec_start_ok[k] || !rec_vld_low[k] || !$onehot(rec_ready[k]))
                begin errors++; $display("FAIL rand%0d[%0d] got id=%0d data=%h ready=%b exp id=%0d data=%h", iter, k, rec_gid[k], rec_data[k], rec_ready[k], exp_id[k], exp_d[k]); end
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rand%0d_spurious got=%0d exp=0", iter, spurious); end
        rand_frames = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_holdoff();
        test_lock();
        test_withdraw();
        for (int r = 0; r < 3; r++) test_random(r);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
